// File: rtl/axi_beat_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_beat_pkg                                                  |
// | Purpose  : Shared AXI burst/response constants, FSM state encodings and  |
// |            a response-severity helper for the beat splitter.             |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package axi_beat_pkg;

  // AXI burst types
  localparam logic [1:0] c_burst_fixed = 2'b00;
  localparam logic [1:0] c_burst_incr  = 2'b01;
  localparam logic [1:0] c_burst_wrap  = 2'b10;

  // AXI response codes, ordered so a larger value is a more severe outcome
  localparam logic [1:0] c_resp_okay   = 2'b00;
  localparam logic [1:0] c_resp_exokay = 2'b01;
  localparam logic [1:0] c_resp_slverr = 2'b10;
  localparam logic [1:0] c_resp_decerr = 2'b11;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_ADDR = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_BEAT = 2'd1,
    W_RESP = 2'd2,
    W_DONE = 2'd3
  } wr_state_t;

  // Keep the worst response seen across the beats of a burst.
  function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_next_addr.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_next_addr                                                 |
// | Purpose  : Combinational AXI next-beat address (FIXED / INCR / WRAP).    |
// | Ports    : addr      - current beat address                              |
// |            len       - burst length minus one                            |
// |            size      - log2 of bytes per beat                            |
// |            burst     - burst type                                        |
// |            next_addr - address of the following beat (mod 2^32)         |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module axi_next_addr
  import axi_beat_pkg::*;
(
  input  logic [31:0] addr,
  input  logic [7:0]  len,
  input  logic [2:0]  size,
  input  logic [1:0]  burst,
  output logic [31:0] next_addr
);

  logic [31:0] w_step;
  logic [31:0] w_incr;
  logic [31:0] w_wrap_mask;
  logic        w_wrap_ok;

  assign w_step = 32'd1 << size;
  assign w_incr = addr + w_step;

  // Only power-of-two lengths 2/4/8/16 may wrap; anything else behaves as INCR.
  assign w_wrap_ok = (burst == c_burst_wrap) &&
                     ((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));

  // Wrap window is (len+1) << size bytes; the mask selects the offset within it.
  assign w_wrap_mask = (({24'd0, len} + 32'd1) << size) - 32'd1;

  always_comb begin
    next_addr = w_incr;
    if (burst == c_burst_fixed) begin
      next_addr = addr;
    end else if (w_wrap_ok) begin
      next_addr = (addr & ~w_wrap_mask) | (w_incr & w_wrap_mask);
    end
  end

endmodule
`default_nettype wire

// File: rtl/axi_beat_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : axi_beat_splitter                                             |
// | Purpose  : Splits upstream AXI read/write bursts into single-beat        |
// |            downstream transactions (len 0, INCR) for a simple memory or  |
// |            UART model. One read and one write burst may be in flight,    |
// |            each handled by its own independent FSM.                      |
// | Ports    : aclk, rst_l (async, active-low)                               |
// |            s_ar*/s_r*        upstream read address / data                |
// |            s_aw*/s_w*/s_b*   upstream write address / data / response    |
// |            m_*               downstream single-beat master port          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module axi_beat_splitter
  import axi_beat_pkg::*;
#(
  parameter int TAGW = 1
) (
  input  logic            aclk,
  input  logic            rst_l,
  // upstream read
  input  logic            s_arvalid,
  output logic            s_arready,
  input  logic [31:0]     s_araddr,
  input  logic [TAGW-1:0] s_arid,
  input  logic [7:0]      s_arlen,
  input  logic [1:0]      s_arburst,
  input  logic [2:0]      s_arsize,
  output logic            s_rvalid,
  input  logic            s_rready,
  output logic [63:0]     s_rdata,
  output logic [1:0]      s_rresp,
  output logic [TAGW-1:0] s_rid,
  output logic            s_rlast,
  // upstream write
  input  logic            s_awvalid,
  output logic            s_awready,
  input  logic [31:0]     s_awaddr,
  input  logic [TAGW-1:0] s_awid,
  input  logic [7:0]      s_awlen,
  input  logic [1:0]      s_awburst,
  input  logic [2:0]      s_awsize,
  input  logic            s_wvalid,
  output logic            s_wready,
  input  logic [63:0]     s_wdata,
  input  logic [7:0]      s_wstrb,
  input  logic            s_wlast,
  output logic            s_bvalid,
  input  logic            s_bready,
  output logic [1:0]      s_bresp,
  output logic [TAGW-1:0] s_bid,
  // downstream read
  output logic            m_arvalid,
  input  logic            m_arready,
  output logic [31:0]     m_araddr,
  output logic [TAGW-1:0] m_arid,
  output logic [7:0]      m_arlen,
  output logic [1:0]      m_arburst,
  output logic [2:0]      m_arsize,
  input  logic            m_rvalid,
  output logic            m_rready,
  input  logic [63:0]     m_rdata,
  input  logic [1:0]      m_rresp,
  input  logic [TAGW-1:0] m_rid,
  input  logic            m_rlast,
  // downstream write
  output logic            m_awvalid,
  input  logic            m_awready,
  output logic [31:0]     m_awaddr,
  output logic [TAGW-1:0] m_awid,
  output logic [7:0]      m_awlen,
  output logic [1:0]      m_awburst,
  output logic [2:0]      m_awsize,
  output logic            m_wvalid,
  input  logic            m_wready,
  output logic [63:0]     m_wdata,
  output logic [7:0]      m_wstrb,
  output logic            m_wlast,
  input  logic            m_bvalid,
  output logic            m_bready,
  input  logic [1:0]      m_bresp,
  input  logic [TAGW-1:0] m_bid
);

  // ---------------------------------------------------------------- read side
  rd_state_t       r_rd_state;
  logic [31:0]     r_rd_addr;
  logic [TAGW-1:0] r_rd_id;
  logic [7:0]      r_rd_len;
  logic [2:0]      r_rd_size;
  logic [1:0]      r_rd_burst;
  logic [7:0]      r_rd_cnt;
  logic [31:0]     w_rd_next;
  logic            w_rd_last;
  logic            w_r_hs;

  axi_next_addr u_rd_next (
    .addr      (r_rd_addr),
    .len       (r_rd_len),
    .size      (r_rd_size),
    .burst     (r_rd_burst),
    .next_addr (w_rd_next)
  );

  // 8-bit counter against 8-bit len: len=255 reaches 255 on the final beat.
  assign w_rd_last = (r_rd_cnt == r_rd_len);
  assign w_r_hs    = (r_rd_state == R_DATA) && m_rvalid && s_rready;

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      r_rd_state <= R_IDLE;
      r_rd_addr  <= '0;
      r_rd_id    <= '0;
      r_rd_len   <= '0;
      r_rd_size  <= '0;
      r_rd_burst <= '0;
      r_rd_cnt   <= '0;
    end else begin
      case (r_rd_state)
        R_IDLE: begin
          if (s_arvalid) begin
            r_rd_addr  <= s_araddr;
            r_rd_id    <= s_arid;
            r_rd_len   <= s_arlen;
            r_rd_size  <= s_arsize;
            r_rd_burst <= s_arburst;
            r_rd_cnt   <= '0;
            r_rd_state <= R_ADDR;
          end
        end
        R_ADDR: begin
          if (m_arready) r_rd_state <= R_DATA;
        end
        R_DATA: begin
          if (w_r_hs) begin
            if (w_rd_last) begin
              r_rd_state <= R_IDLE;
            end else begin
              r_rd_addr  <= w_rd_next;
              r_rd_cnt   <= r_rd_cnt + 8'd1;
              r_rd_state <= R_ADDR;
            end
          end
        end
        default: r_rd_state <= R_IDLE;
      endcase
    end
  end

  assign s_arready = (r_rd_state == R_IDLE);
  assign m_arvalid = (r_rd_state == R_ADDR);
  assign m_araddr  = r_rd_addr;
  assign m_arid    = r_rd_id;
  assign m_arlen   = 8'd0;
  assign m_arburst = c_burst_incr;
  assign m_arsize  = r_rd_size;
  assign s_rvalid  = (r_rd_state == R_DATA) && m_rvalid;
  assign m_rready  = (r_rd_state == R_DATA) && s_rready;
  assign s_rdata   = m_rdata;
  assign s_rresp   = m_rresp;
  assign s_rid     = r_rd_id;
  // Downstream beats are all single-beat, so last is derived from our own count.
  assign s_rlast   = (r_rd_state == R_DATA) && w_rd_last;

  // --------------------------------------------------------------- write side
  wr_state_t       r_wr_state;
  logic [31:0]     r_wr_addr;
  logic [TAGW-1:0] r_wr_id;
  logic [7:0]      r_wr_len;
  logic [2:0]      r_wr_size;
  logic [1:0]      r_wr_burst;
  logic [7:0]      r_wr_cnt;
  logic [1:0]      r_resp_acc;
  logic [31:0]     w_wr_next;
  logic            w_wr_last;
  logic            w_w_hs;

  axi_next_addr u_wr_next (
    .addr      (r_wr_addr),
    .len       (r_wr_len),
    .size      (r_wr_size),
    .burst     (r_wr_burst),
    .next_addr (w_wr_next)
  );

  assign w_wr_last = (r_wr_cnt == r_wr_len);
  // Downstream raises awready and wready together, so one handshake covers both.
  assign w_w_hs    = (r_wr_state == W_BEAT) && s_wvalid && m_awready && m_wready;

  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      r_wr_state <= W_IDLE;
      r_wr_addr  <= '0;
      r_wr_id    <= '0;
      r_wr_len   <= '0;
      r_wr_size  <= '0;
      r_wr_burst <= '0;
      r_wr_cnt   <= '0;
      r_resp_acc <= c_resp_okay;
    end else begin
      case (r_wr_state)
        W_IDLE: begin
          if (s_awvalid) begin
            r_wr_addr  <= s_awaddr;
            r_wr_id    <= s_awid;
            r_wr_len   <= s_awlen;
            r_wr_size  <= s_awsize;
            r_wr_burst <= s_awburst;
            r_wr_cnt   <= '0;
            r_resp_acc <= c_resp_okay;
            r_wr_state <= W_BEAT;
          end
        end
        W_BEAT: begin
          if (w_w_hs) begin
            // A wlast that disagrees with our beat count marks the burst bad.
            if (s_wlast != w_wr_last) r_resp_acc <= resp_max(r_resp_acc, c_resp_slverr);
            r_wr_state <= W_RESP;
          end
        end
        W_RESP: begin
          if (m_bvalid) begin
            r_resp_acc <= resp_max(r_resp_acc, m_bresp);
            if (w_wr_last) begin
              r_wr_state <= W_DONE;
            end else begin
              r_wr_addr  <= w_wr_next;
              r_wr_cnt   <= r_wr_cnt + 8'd1;
              r_wr_state <= W_BEAT;
            end
          end
        end
        W_DONE: begin
          if (s_bready) r_wr_state <= W_IDLE;
        end
        default: r_wr_state <= W_IDLE;
      endcase
    end
  end

  assign s_awready = (r_wr_state == W_IDLE);
  assign m_awvalid = (r_wr_state == W_BEAT) && s_wvalid;
  assign m_wvalid  = (r_wr_state == W_BEAT) && s_wvalid;
  assign s_wready  = (r_wr_state == W_BEAT) && m_awready && m_wready;
  assign m_awaddr  = r_wr_addr;
  assign m_awid    = r_wr_id;
  assign m_awlen   = 8'd0;
  assign m_awburst = c_burst_incr;
  assign m_awsize  = r_wr_size;
  assign m_wdata   = s_wdata;
  assign m_wstrb   = s_wstrb;
  assign m_wlast   = 1'b1;
  assign m_bready  = (r_wr_state == W_RESP);
  assign s_bvalid  = (r_wr_state == W_DONE);
  assign s_bresp   = r_resp_acc;
  assign s_bid     = r_wr_id;

  // Downstream ids and rlast carry no information for single-beat traffic.
  logic w_unused;
  assign w_unused = &{1'b0, m_rid, m_rlast, m_bid};

endmodule
`default_nettype wire

// File: tb/tb_axi_beat_splitter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_axi_beat_splitter                                          |
// | Purpose  : Scoreboard bench for axi_beat_splitter with a single-beat     |
// |            downstream memory model and directed burst vectors.           |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_axi_beat_splitter;

  logic        aclk = 1'b0;
  logic        rst_l;
  logic        s_arvalid, s_arready;
  logic [31:0] s_araddr;
  logic [0:0]  s_arid;
  logic [7:0]  s_arlen;
  logic [1:0]  s_arburst;
  logic [2:0]  s_arsize;
  logic        s_rvalid, s_rready;
  logic [63:0] s_rdata;
  logic [1:0]  s_rresp;
  logic [0:0]  s_rid;
  logic        s_rlast;
  logic        s_awvalid, s_awready;
  logic [31:0] s_awaddr;
  logic [0:0]  s_awid;
  logic [7:0]  s_awlen;
  logic [1:0]  s_awburst;
  logic [2:0]  s_awsize;
  logic        s_wvalid, s_wready;
  logic [63:0] s_wdata;
  logic [7:0]  s_wstrb;
  logic        s_wlast;
  logic        s_bvalid, s_bready;
  logic [1:0]  s_bresp;
  logic [0:0]  s_bid;
  logic        m_arvalid, m_arready;
  logic [31:0] m_araddr;
  logic [0:0]  m_arid;
  logic [7:0]  m_arlen;
  logic [1:0]  m_arburst;
  logic [2:0]  m_arsize;
  logic        m_rvalid, m_rready;
  logic [63:0] m_rdata;
  logic [1:0]  m_rresp;
  logic [0:0]  m_rid;
  logic        m_rlast;
  logic        m_awvalid, m_awready;
  logic [31:0] m_awaddr;
  logic [0:0]  m_awid;
  logic [7:0]  m_awlen;
  logic [1:0]  m_awburst;
  logic [2:0]  m_awsize;
  logic        m_wvalid, m_wready;
  logic [63:0] m_wdata;
  logic [7:0]  m_wstrb;
  logic        m_wlast;
  logic        m_bvalid, m_bready;
  logic [1:0]  m_bresp;
  logic [0:0]  m_bid;

  axi_beat_splitter #(.TAGW(1)) dut (
    .aclk(aclk), .rst_l(rst_l),
    .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arid(s_arid),
    .s_arlen(s_arlen), .s_arburst(s_arburst), .s_arsize(s_arsize),
    .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp),
    .s_rid(s_rid), .s_rlast(s_rlast),
    .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awid(s_awid),
    .s_awlen(s_awlen), .s_awburst(s_awburst), .s_awsize(s_awsize),
    .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_wlast(s_wlast), .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
    .s_bid(s_bid),
    .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr), .m_arid(m_arid),
    .m_arlen(m_arlen), .m_arburst(m_arburst), .m_arsize(m_arsize),
    .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rresp(m_rresp),
    .m_rid(m_rid), .m_rlast(m_rlast),
    .m_awvalid(m_awvalid), .m_awready(m_awready), .m_awaddr(m_awaddr), .m_awid(m_awid),
    .m_awlen(m_awlen), .m_awburst(m_awburst), .m_awsize(m_awsize),
    .m_wvalid(m_wvalid), .m_wready(m_wready), .m_wdata(m_wdata), .m_wstrb(m_wstrb),
    .m_wlast(m_wlast), .m_bvalid(m_bvalid), .m_bready(m_bready), .m_bresp(m_bresp),
    .m_bid(m_bid)
  );

  always #5 aclk = ~aclk;

  // ------------------------------------------------------------ check helpers
  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // ------------------------------------------------------- downstream model
  function automatic logic [63:0] mem_data(input logic [31:0] a);
    return {a ^ 32'hDEAD_BEEF, a};
  endfunction

  int err_beat = -1;  // write beat index that answers SLVERR (-1: none)
  int wr_idx;

  always @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      m_rvalid <= 1'b0;
      m_rdata  <= '0;
      m_bvalid <= 1'b0;
      m_bresp  <= 2'b00;
      wr_idx   <= 0;
    end else begin
      if (m_arvalid && m_arready) begin
        m_rvalid <= 1'b1;
        m_rdata  <= mem_data(m_araddr);
      end else if (m_rvalid && m_rready) begin
        m_rvalid <= 1'b0;
      end
      if (s_awvalid && s_awready) wr_idx <= 0;
      if (m_awvalid && m_wvalid && m_awready && m_wready) begin
        m_bvalid <= 1'b1;
        m_bresp  <= (wr_idx == err_beat) ? 2'b10 : 2'b00;
        wr_idx   <= wr_idx + 1;
      end else if (m_bvalid && m_bready) begin
        m_bvalid <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------- scoreboard
  typedef struct packed { logic [31:0] addr; logic [0:0] id; logic [2:0] size; } ar_t;
  typedef struct packed { logic [63:0] data; logic last; logic [0:0] id; } r_t;
  typedef struct packed { logic [31:0] addr; logic [63:0] data; logic [7:0] strb; logic [0:0] id; } aw_t;
  typedef struct packed { logic [1:0] resp; logic [0:0] id; } b_t;

  ar_t exp_ar[$];
  r_t  exp_r[$];
  aw_t exp_aw[$];
  b_t  exp_b[$];
  ar_t ar_e;
  r_t  r_e;
  aw_t aw_e;
  b_t  b_e;
  int  n_r_seen = 0;
  logic        hold_v = 1'b0;
  logic [63:0] hold_d;

  always @(negedge aclk) begin
    if (!rst_l) begin
      hold_v = 1'b0;
    end else begin
      if (m_arvalid && m_arready) begin
        if (exp_ar.size() == 0) chk("ar_unexpected", {32'd0, m_araddr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          ar_e = exp_ar.pop_front();
          chk("m_araddr", {32'd0, m_araddr}, {32'd0, ar_e.addr});
          chk("m_ar_fields", {m_arid, m_arlen, m_arburst, m_arsize},
              {ar_e.id, 8'd0, 2'b01, ar_e.size});
        end
      end
      if (hold_v) begin
        chk("rvalid_held", {63'd0, s_rvalid}, 64'd1);
        chk("rdata_held", s_rdata, hold_d);
      end
      hold_v = s_rvalid && !s_rready;
      hold_d = s_rdata;
      if (s_rvalid && s_rready) begin
        n_r_seen++;
        if (exp_r.size() == 0) chk("r_unexpected", s_rdata, ~s_rdata);
        else begin
          r_e = exp_r.pop_front();
          chk("s_rdata", s_rdata, r_e.data);
          chk("s_rlast_rid_rresp", {s_rlast, s_rid, s_rresp}, {r_e.last, r_e.id, 2'b00});
        end
      end
      if (m_awvalid && m_wvalid && m_awready && m_wready) begin
        if (exp_aw.size() == 0) chk("aw_unexpected", {32'd0, m_awaddr}, 64'hFFFF_FFFF_FFFF_FFFF);
        else begin
          aw_e = exp_aw.pop_front();
          chk("m_awaddr", {32'd0, m_awaddr}, {32'd0, aw_e.addr});
          chk("m_wdata", m_wdata, aw_e.data);
          chk("m_aw_fields", {m_wstrb, m_awid, m_awlen, m_awburst, m_wlast},
              {aw_e.strb, aw_e.id, 8'd0, 2'b01, 1'b1});
        end
      end
      if (s_bvalid && s_bready) begin
        if (exp_b.size() == 0) chk("b_unexpected", {62'd0, s_bresp}, 64'hFF);
        else begin
          b_e = exp_b.pop_front();
          chk("s_bresp_bid", {s_bresp, s_bid}, {b_e.resp, b_e.id});
        end
      end
    end
  end

  // ------------------------------------------------------------ stimulus
  task automatic exp_read(input logic [31:0] a, input logic [0:0] id, input logic [2:0] sz,
                          input logic last);
    exp_ar.push_back('{addr: a, id: id, size: sz});
    exp_r.push_back('{data: mem_data(a), last: last, id: id});
  endtask

  task automatic exp_write(input logic [31:0] a, input logic [63:0] d, input logic [7:0] st,
                           input logic [0:0] id);
    exp_aw.push_back('{addr: a, data: d, strb: st, id: id});
  endtask

  task automatic send_ar(input logic [31:0] a, input logic [0:0] id, input logic [7:0] len,
                         input logic [2:0] sz, input logic [1:0] bt);
    s_arvalid = 1'b1; s_araddr = a; s_arid = id; s_arlen = len; s_arsize = sz; s_arburst = bt;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_arready) break;
    end
    @(posedge aclk); #1;
    s_arvalid = 1'b0;
  endtask

  task automatic send_aw(input logic [31:0] a, input logic [0:0] id, input logic [7:0] len);
    s_awvalid = 1'b1; s_awaddr = a; s_awid = id; s_awlen = len; s_awsize = 3'd3;
    s_awburst = 2'b01;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_awready) break;
    end
    @(posedge aclk); #1;
    s_awvalid = 1'b0;
  endtask

  task automatic send_w(input logic [63:0] d, input logic [7:0] st, input logic last);
    s_wvalid = 1'b1; s_wdata = d; s_wstrb = st; s_wlast = last;
    for (int i = 0; i < 100; i++) begin
      @(negedge aclk);
      if (s_wready) break;
    end
    @(posedge aclk); #1;
    s_wvalid = 1'b0;
  endtask

  task automatic wait_r(input int target);
    for (int i = 0; i < 200; i++) begin
      @(posedge aclk);
      if (n_r_seen >= target) break;
    end
    #1;
    chk("r_beat_reached", {63'd0, n_r_seen >= target}, 64'd1);
  endtask

  task automatic drain(input string nm);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 600; i++) begin
      @(posedge aclk);
      if (exp_ar.size() == 0 && exp_r.size() == 0 && exp_aw.size() == 0 &&
          exp_b.size() == 0 && s_arready && s_awready) begin
        ok = 1'b1;
        break;
      end
    end
    #1;
    chk(nm, {63'd0, ok}, 64'd1);
  endtask

  initial begin
    rst_l = 1'b0;
    s_arvalid = 0; s_araddr = 0; s_arid = 0; s_arlen = 0; s_arburst = 0; s_arsize = 0;
    s_rready = 1;
    s_awvalid = 0; s_awaddr = 0; s_awid = 0; s_awlen = 0; s_awburst = 0; s_awsize = 0;
    s_wvalid = 0; s_wdata = 0; s_wstrb = 0; s_wlast = 0; s_bready = 1;
    m_arready = 1; m_awready = 1; m_wready = 1;
    m_rresp = 2'b00; m_rid = 1'b0; m_rlast = 1'b1; m_bid = 1'b0;
    #3;
    chk("reset_readies", {62'd0, s_arready, s_awready}, 64'd3);
    chk("reset_valids", {58'd0, s_rvalid, s_bvalid, m_arvalid, m_awvalid, m_wvalid, s_wready},
        64'd0);
    repeat (3) @(posedge aclk);
    #1 rst_l = 1'b1;
    @(posedge aclk); #1;

    // INCR read, 4 beats of 8 bytes
    exp_read(32'h1000, 1'b1, 3'd3, 1'b0);
    exp_read(32'h1008, 1'b1, 3'd3, 1'b0);
    exp_read(32'h1010, 1'b1, 3'd3, 1'b0);
    exp_read(32'h1018, 1'b1, 3'd3, 1'b1);
    send_ar(32'h1000, 1'b1, 8'd3, 3'd3, 2'b01);
    drain("drain_incr_read");

    // WRAP read across a 32-byte window
    exp_read(32'h1018, 1'b0, 3'd3, 1'b0);
    exp_read(32'h1000, 1'b0, 3'd3, 1'b0);
    exp_read(32'h1008, 1'b0, 3'd3, 1'b0);
    exp_read(32'h1010, 1'b0, 3'd3, 1'b1);
    send_ar(32'h1018, 1'b0, 8'd3, 3'd3, 2'b10);
    drain("drain_wrap_read");

    // Upstream stall of 3 cycles in the middle of a burst
    exp_read(32'h3000, 1'b1, 3'd3, 1'b0);
    exp_read(32'h3008, 1'b1, 3'd3, 1'b0);
    exp_read(32'h3010, 1'b1, 3'd3, 1'b0);
    exp_read(32'h3018, 1'b1, 3'd3, 1'b1);
    send_ar(32'h3000, 1'b1, 8'd3, 3'd3, 2'b01);
    wait_r(1);
    s_rready = 1'b0;
    repeat (3) @(posedge aclk);
    #1 s_rready = 1'b1;
    drain("drain_stall_read");

    // Address arithmetic rolls over 2^32
    exp_read(32'hFFFF_FFF8, 1'b0, 3'd3, 1'b0);
    exp_read(32'h0000_0000, 1'b0, 3'd3, 1'b1);
    send_ar(32'hFFFF_FFF8, 1'b0, 8'd1, 3'd3, 2'b01);
    drain("drain_rollover_read");

    // INCR write, 2 beats, all OK
    exp_write(32'h2000, 64'h1111_2222_3333_4444, 8'hFF, 1'b1);
    exp_write(32'h2008, 64'h5555_6666_7777_8888, 8'hFF, 1'b1);
    exp_b.push_back('{resp: 2'b00, id: 1'b1});
    send_aw(32'h2000, 1'b1, 8'd1);
    send_w(64'h1111_2222_3333_4444, 8'hFF, 1'b0);
    send_w(64'h5555_6666_7777_8888, 8'hFF, 1'b1);
    drain("drain_incr_write");

    // Second beat answers SLVERR; s_bready held off 5 cycles
    err_beat = 1;
    s_bready = 1'b0;
    exp_write(32'h2100, 64'hAAAA_0000_0000_0001, 8'h0F, 1'b0);
    exp_write(32'h2108, 64'hAAAA_0000_0000_0002, 8'hF0, 1'b0);
    exp_b.push_back('{resp: 2'b10, id: 1'b0});
    send_aw(32'h2100, 1'b0, 8'd1);
    send_w(64'hAAAA_0000_0000_0001, 8'h0F, 1'b0);
    send_w(64'hAAAA_0000_0000_0002, 8'hF0, 1'b1);
    for (int i = 0; i < 50; i++) begin
      @(negedge aclk);
      if (s_bvalid) break;
    end
    for (int i = 0; i < 5; i++) begin
      chk("bvalid_held", {63'd0, s_bvalid}, 64'd1);
      @(negedge aclk);
    end
    @(posedge aclk); #1 s_bready = 1'b1;
    err_beat = -1;
    drain("drain_slverr_write");

    // wlast asserted early: burst reported as SLVERR
    exp_write(32'h2200, 64'h0BAD_0000_0000_0001, 8'hFF, 1'b1);
    exp_write(32'h2208, 64'h0BAD_0000_0000_0002, 8'hFF, 1'b1);
    exp_b.push_back('{resp: 2'b10, id: 1'b1});
    send_aw(32'h2200, 1'b1, 8'd1);
    send_w(64'h0BAD_0000_0000_0001, 8'hFF, 1'b1);
    send_w(64'h0BAD_0000_0000_0002, 8'hFF, 1'b1);
    drain("drain_wlast_write");

    // AR and AW in the same cycle; FIXED read of 4-byte beats
    exp_read(32'h4000, 1'b1, 3'd2, 1'b0);
    exp_read(32'h4000, 1'b1, 3'd2, 1'b1);
    exp_write(32'h5000, 64'hC0DE_C0DE_C0DE_C0DE, 8'h3C, 1'b0);
    exp_b.push_back('{resp: 2'b00, id: 1'b0});
    fork
      send_ar(32'h4000, 1'b1, 8'd1, 3'd2, 2'b00);
      begin
        send_aw(32'h5000, 1'b0, 8'd0);
        send_w(64'hC0DE_C0DE_C0DE_C0DE, 8'h3C, 1'b1);
      end
    join
    drain("drain_concurrent");

    // Reset during beat 2 of an 8-beat read, then a fresh read
    for (int i = 0; i < 8; i++) exp_read(32'h6000 + 32'(i * 8), 1'b1, 3'd3, i == 7);
    n_r_seen = 0;
    send_ar(32'h6000, 1'b1, 8'd7, 3'd3, 2'b01);
    wait_r(1);
    rst_l = 1'b0;
    #1;
    chk("midrst_readies", {62'd0, s_arready, s_awready}, 64'd3);
    chk("midrst_valids", {61'd0, s_rvalid, m_arvalid, s_bvalid}, 64'd0);
    exp_ar.delete();
    exp_r.delete();
    repeat (2) @(posedge aclk);
    #1 rst_l = 1'b1;
    @(posedge aclk); #1;
    exp_read(32'h7000, 1'b0, 3'd3, 1'b1);
    send_ar(32'h7000, 1'b0, 8'd0, 3'd3, 2'b01);
    drain("drain_after_reset");

    repeat (5) @(posedge aclk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
